rob_commit: RTL and testbench

Reorder buffer with in-order commit for the Tomasulo core. Accepts one allocation per cycle from the issue stage and captures results from the common data bus (CDB). Retires completed entries strictly in program order through a registered register-bank write port. Also holds the register status table (producer tag per architectural register) that issue uses to rename source operands.

---
 rtl/rob_commit_pkg.sv | 25 ++
 rtl/rob_status_table.sv | 38 +++
 rtl/rob_commit.sv | 115 +++++++++++
 tb/tb_rob_commit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared ROB parameters and entry layout for the Tomasulo core
// (also used by the add/mul reservation stations).
package rob_commit_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;

    localparam logic [TAG_W:0] NO_TAG   = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    function automatic logic [TAG_W:0] tag_ext(input logic [TAG_W-1:0] t);
        return {1'b0, t};
    endfunction

endpackage

// File: rtl/rob_status_table.sv
// Register status (rename) table: producer ROB tag per architectural
// register, or NO_TAG when the value lives in the register bank.
module rob_status_table
    import rob_commit_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_reg,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_reg,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic [REG_W-1:0] rd_reg,
    output logic [TAG_W:0]   rd_tag
);

    logic [TAG_W:0] tbl [NREGS];

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                tbl[i] <= NO_TAG;
            end
        end else begin
            // set is written last so an allocation to the same register wins
            if (clr_en && (tbl[clr_reg] == tag_ext(clr_tag))) begin
                tbl[clr_reg] <= NO_TAG;
            end
            if (set_en) begin
                tbl[set_reg] <= tag_ext(set_tag);
            end
        end
    end

    assign rd_tag = tbl[rd_reg];

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: one allocation per cycle, CDB result capture,
// strictly in-order retire through a registered register-bank write port.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_dest,
    output logic              iss_ready,
    output logic [TAG_W-1:0]  iss_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [REG_W-1:0]  rd_reg,
    output logic [TAG_W:0]    rd_tag,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              cmt_valid,
    output logic [REG_W-1:0]  cmt_reg,
    output logic [DATA_W-1:0] cmt_data,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);

    rob_entry_t       rob [DEPTH];
    logic [TAG_W-1:0] head_p;
    logic [TAG_W-1:0] tail_p;
    logic [TAG_W:0]   cnt;
    logic             do_alloc;
    logic             do_commit;
    logic             cdb_hit;
    logic [TAG_W-1:0] lk_tag;

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign iss_ready = !full;
    assign iss_tag   = tail_p;
    assign count     = cnt;

    assign do_alloc  = iss_valid && !full;
    assign do_commit = rob[head_p].busy && rob[head_p].done;
    assign cdb_hit   = cdb_valid && rob[cdb_tag].busy && !rob[cdb_tag].done;

    always_ff @(posedge clk1) begin
        if (rst) begin
            head_p    <= '0;
            tail_p    <= '0;
            cnt       <= '0;
            cmt_valid <= 1'b0;
            cmt_reg   <= '0;
            cmt_data  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else begin
            cmt_valid <= do_commit;
            if (do_commit) begin
                cmt_reg          <= rob[head_p].dest;
                cmt_data         <= rob[head_p].value;
                rob[head_p].busy <= 1'b0;
                rob[head_p].done <= 1'b0;
                head_p           <= head_p + 1'b1;
            end
            if (cdb_hit) begin
                rob[cdb_tag].done  <= 1'b1;
                rob[cdb_tag].value <= cdb_data;
            end
            // tail entry is never busy when not full, so no overlap with commit/CDB
            if (do_alloc) begin
                rob[tail_p].busy  <= 1'b1;
                rob[tail_p].done  <= 1'b0;
                rob[tail_p].dest  <= iss_dest;
                rob[tail_p].value <= '0;
                tail_p            <= tail_p + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    rob_status_table u_status (
        .clk1    (clk1),
        .rst     (rst),
        .set_en  (do_alloc),
        .set_reg (iss_dest),
        .set_tag (tail_p),
        .clr_en  (do_commit),
        .clr_reg (rob[head_p].dest),
        .clr_tag (head_p),
        .rd_reg  (rd_reg),
        .rd_tag  (rd_tag)
    );

    assign lk_tag = rd_tag[TAG_W-1:0];

    always_comb begin
        rd_ready = 1'b0;
        rd_data  = '0;
        if (!rd_tag[TAG_W]) begin
            if (rob[lk_tag].done) begin
                rd_ready = 1'b1;
                rd_data  = rob[lk_tag].value;
            end else if (cdb_valid && (cdb_tag == lk_tag)) begin
                rd_ready = 1'b1;
                rd_data  = cdb_data;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, checked
// against a queue-based in-order model of the reorder buffer.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [3:0]  iss_dest;
    logic        iss_ready;
    logic [2:0]  iss_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [3:0]  rd_reg;
    logic [3:0]  rd_tag;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        cmt_valid;
    logic [3:0]  cmt_reg;
    logic [15:0] cmt_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    rob_commit dut (
        .clk1      (clk1),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_ready (iss_ready),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .rd_reg    (rd_reg),
        .rd_tag    (rd_tag),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .cmt_valid (cmt_valid),
        .cmt_reg   (cmt_reg),
        .cmt_data  (cmt_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int tag;
        int dest;
        bit done;
        int value;
    } ent_t;

    ent_t q[$];
    int   rt[16];
    int   ntag;
    bit   exp_cv;
    int   exp_cr;
    int   exp_cd;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < 16; r++) rt[r] = 8;
        ntag   = 0;
        exp_cv = 0;
        exp_cr = 0;
        exp_cd = 0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_update();
        bit   com;
        bit   alc;
        ent_t e;
        com = (q.size() > 0) && q[0].done;
        alc = iss_valid && (q.size() < 8);
        if (cdb_valid) begin
            foreach (q[k]) begin
                if (q[k].tag == int'(cdb_tag) && !q[k].done) begin
                    q[k].done  = 1;
                    q[k].value = int'(cdb_data);
                end
            end
        end
        exp_cv = com;
        if (com) begin
            e      = q.pop_front();
            exp_cr = e.dest;
            exp_cd = e.value;
            if (rt[e.dest] == e.tag) rt[e.dest] = 8;
        end
        if (alc) begin
            q.push_back('{ntag, int'(iss_dest), 1'b0, 0});
            rt[iss_dest] = ntag;
            ntag = (ntag + 1) % 8;
        end
    endtask

    task automatic check_reg();
        chk_val("cmt_valid", int'(cmt_valid), int'(exp_cv));
        if (exp_cv) begin
            chk_val("cmt_reg", int'(cmt_reg), exp_cr);
            chk_val("cmt_data", int'(cmt_data), exp_cd);
        end
        chk_val("count", int'(count), q.size());
        chk_val("full", int'(full), int'(q.size() == 8));
        chk_val("empty", int'(empty), int'(q.size() == 0));
        chk_val("iss_ready", int'(iss_ready), int'(q.size() < 8));
        chk_val("iss_tag", int'(iss_tag), ntag);
    endtask

    task automatic check_comb();
        int t;
        int er;
        int ed;
        t  = rt[rd_reg];
        er = 0;
        ed = 0;
        if (t != 8) begin
            foreach (q[k]) begin
                if (q[k].tag == t) begin
                    if (q[k].done) begin
                        er = 1;
                        ed = q[k].value;
                    end else if (cdb_valid && int'(cdb_tag) == t) begin
                        er = 1;
                        ed = int'(cdb_data);
                    end
                end
            end
        end
        chk_val("rd_tag", int'(rd_tag), t);
        chk_val("rd_ready", int'(rd_ready), er);
        chk_val("rd_data", int'(rd_data), ed);
    endtask

    task automatic drive(input bit iv, input int id, input bit cv, input int ct,
                         input int cd, input int rr);
        iss_valid = iv;
        iss_dest  = 4'(id);
        cdb_valid = cv;
        cdb_tag   = 3'(ct);
        cdb_data  = 16'(cd);
        rd_reg    = 4'(rr);
        #1;
        check_comb();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk1);
        #1;
        check_reg();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        iss_valid = 1'b0;
        iss_dest  = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        rd_reg    = '0;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        rst = 1'b0;
        model_reset();
        check_reg();
    endtask

    initial begin
        do_reset();
        for (int r = 0; r < 16; r++) begin
            rd_reg = 4'(r);
            #1;
            chk_val("reset_rd_tag", int'(rd_tag), 8);
        end

        // in-order retire with out-of-order completion
        drive(1, 3, 0, 0, 0, 3); tick();
        drive(1, 5, 0, 0, 0, 3); tick();
        drive(1, 7, 0, 0, 0, 5); tick();
        drive(0, 0, 1, 2, 'h0022, 7); tick();
        drive(0, 0, 1, 0, 'h0011, 3); tick();
        chk_val("inord_early", int'(cmt_valid), 0);
        drive(0, 0, 1, 1, 'h0033, 5); tick();
        chk_val("inord_c0", {int'(cmt_valid), int'(cmt_reg), int'(cmt_data)}, {1, 3, 'h0011});
        drive(0, 0, 0, 0, 0, 7); tick();
        chk_val("inord_c1", {int'(cmt_valid), int'(cmt_reg), int'(cmt_data)}, {1, 5, 'h0033});
        drive(0, 0, 0, 0, 0, 7); tick();
        chk_val("inord_c2", {int'(cmt_valid), int'(cmt_reg), int'(cmt_data)}, {1, 7, 'h0022});
        drive(0, 0, 0, 0, 0, 7); tick();

        // full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 0, 0, 0, i); tick();
        end
        chk_val("full_flag", int'(full), 1);
        chk_val("full_ready", int'(iss_ready), 0);
        drive(1, 9, 0, 0, 0, 9); tick();
        chk_val("full_ignored", int'(count), 8);
        drive(0, 0, 1, 0, 'h1111, 0); tick();
        chk_val("full_no_rise", int'(iss_ready), 0);
        drive(0, 0, 0, 0, 0, 0); tick();
        chk_val("wrap_tag", int'(iss_tag), 0);
        chk_val("wrap_ready", int'(iss_ready), 1);
        drive(1, 10, 0, 0, 0, 10); tick();
        chk_val("wrap_rename", int'(rd_tag), 0);

        // rename: older commit must not clear a newer producer
        do_reset();
        drive(1, 4, 0, 0, 0, 4); tick();
        drive(1, 4, 0, 0, 0, 4); tick();
        drive(0, 0, 1, 0, 'h0A0A, 4); tick();
        drive(0, 0, 0, 0, 0, 4); tick();
        drive(0, 0, 0, 0, 0, 4);
        chk_val("rename_keep", int'(rd_tag), 1);
        tick();
        drive(0, 0, 1, 1, 'h0B0B, 4); tick();
        drive(0, 0, 0, 0, 0, 4); tick();
        drive(0, 0, 0, 0, 0, 4);
        chk_val("rename_clear", int'(rd_tag), 8);
        tick();

        // CDB bypass on lookup
        do_reset();
        drive(1, 4, 0, 0, 0, 4); tick();
        drive(0, 0, 1, 0, 'hBEEF, 4);
        chk_val("bypass_ready", int'(rd_ready), 1);
        chk_val("bypass_data", int'(rd_data), 'hBEEF);
        tick();

        // spurious and duplicate CDB
        do_reset();
        drive(1, 2, 0, 0, 0, 2); tick();
        drive(0, 0, 1, 5, 'hDEAD, 2); tick();
        chk_val("spur_nocmt", int'(cmt_valid), 0);
        chk_val("spur_count", int'(count), 1);
        drive(0, 0, 1, 0, 'h1234, 2); tick();
        drive(0, 0, 1, 0, 'h9999, 2); tick();
        chk_val("dup_keep", {int'(cmt_valid), int'(cmt_data)}, {1, 'h1234});
        drive(0, 0, 1, 0, 'h5555, 2); tick();

        // random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int ct;
            if (q.size() > 0 && ($urandom % 4) != 0) ct = q[$urandom % q.size()].tag;
            else ct = $urandom % 8;
            drive(($urandom % 10) < 6, $urandom_range(0, 5), ($urandom % 3) != 0,
                  ct, $urandom, $urandom_range(0, 6));
            tick();
        end

        // reset mid-operation: everything discarded, no trailing strobe
        for (int c = 0; c < 6; c++) begin
            drive(1, c, 1, (c + 7) % 8, c * 3 + 1, c);
            tick();
        end
        do_reset();
        chk_val("midrst_nocmt", int'(cmt_valid), 0);
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 2); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
